// File: rtl/tdp18k_fifo_ctrl.sv
// tdp18k_fifo_ctrl
// Single-clock FIFO controller for one 18Kb half of a dual-18K true-dual-port
// RAM. Port A of the half is the write port, port B is the read port, both at
// x18 (16 data + 2 parity). Even parity is generated per byte on write and
// checked on read. The 1-cycle RAM read latency is hidden behind a 2-entry
// first-word-fall-through output buffer.
//
// Ports:
//   CLK, RESET (async, active high), FLUSH (sync clear)
//   WR_EN / WR_DATA                  push side; FULL, ALMOST_FULL, WR_OVERFLOW
//   O_VALID / O_READY / O_DATA       pop side; O_PERR flags the head word
//   EMPTY, ALMOST_EMPTY, COUNT       occupancy (RAM + in-flight + buffer)
//   PARITY_ERR                       sticky, cleared by RESET or FLUSH
//   RAM_*_A                          RAM port A write controls
//   RAM_*_B                          RAM port B read controls / read data
//
// Handshake: a word leaves the FIFO in every cycle where O_VALID and O_READY
// are both high. While O_VALID is high and O_READY is low, O_DATA/O_PERR stay
// stable. WR_EN has no ready; a push is taken only when FULL is low.
module tdp18k_fifo_ctrl #(
  parameter int DEPTH_LOG2    = 10,
  parameter int ADDR_LSB      = 4,
  parameter int AFULL_THRESH  = 1020,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  WR_EN,
  input  logic [15:0]           WR_DATA,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic                  WR_OVERFLOW,
  output logic                  O_VALID,
  input  logic                  O_READY,
  output logic [15:0]           O_DATA,
  output logic                  O_PERR,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  PARITY_ERR,
  output logic                  RAM_WEN_A,
  output logic [1:0]            RAM_BE_A,
  output logic [13:0]           RAM_ADDR_A,
  output logic [15:0]           RAM_WDATA_A,
  output logic [1:0]            RAM_WPARITY_A,
  output logic                  RAM_REN_B,
  output logic [13:0]           RAM_ADDR_B,
  input  logic [15:0]           RAM_RDATA_B,
  input  logic [1:0]            RAM_RPARITY_B
);

  localparam logic [DEPTH_LOG2:0] DEPTH_W   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] AFULL_W   = AFULL_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AEMPTY_W  = AEMPTY_THRESH[DEPTH_LOG2:0];

  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   ram_cnt, count_q;
  logic                  rd_pending;
  logic [1:0]            buf_cnt;
  logic                  head;
  logic [1:0][15:0]      buf_data;
  logic [1:0]            buf_perr;
  logic                  ovf_q, perr_sticky;

  logic                  accept, pop, issue, tail, cap_perr;
  logic [1:0]            wr_parity, rd_parity;
  logic [2:0]            buf_after;
  logic [DEPTH_LOG2:0]   ram_cnt_nxt, count_nxt;
  logic [1:0]            buf_cnt_nxt;

  assign FULL         = (count_q == DEPTH_W);
  assign EMPTY        = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= AFULL_W);
  assign ALMOST_EMPTY = (count_q <= AEMPTY_W);
  assign COUNT        = count_q;
  assign WR_OVERFLOW  = ovf_q;
  assign PARITY_ERR   = perr_sticky;

  assign O_VALID = (buf_cnt != 2'd0);
  assign O_DATA  = buf_data[head];
  assign O_PERR  = buf_perr[head];
  assign pop     = O_VALID & O_READY;

  // RESET gates accept so the write port is quiet while reset is held.
  assign accept    = WR_EN & ~FULL & ~FLUSH & ~RESET;
  assign wr_parity = {^WR_DATA[15:8], ^WR_DATA[7:0]};

  // Only fetch when the word will have a buffer slot on arrival: entries
  // already held plus the one in flight, minus the one leaving this cycle.
  assign buf_after = {1'b0, buf_cnt} + {2'b00, rd_pending} - {2'b00, pop};
  assign issue     = (ram_cnt != '0) & (buf_after < 3'd2) & ~FLUSH;

  // Write data/parity are zeroed when not writing so idle outputs are clean.
  assign RAM_WEN_A     = accept;
  assign RAM_BE_A      = {2{accept}};
  assign RAM_ADDR_A    = 14'({wptr, {ADDR_LSB{1'b0}}});
  assign RAM_WDATA_A   = accept ? WR_DATA : 16'h0000;
  assign RAM_WPARITY_A = accept ? wr_parity : 2'b00;
  assign RAM_REN_B     = issue;
  assign RAM_ADDR_B    = 14'({rptr, {ADDR_LSB{1'b0}}});

  assign rd_parity = {^RAM_RDATA_B[15:8], ^RAM_RDATA_B[7:0]};
  assign cap_perr  = rd_pending & (rd_parity != RAM_RPARITY_B);

  // A capture always finds buf_cnt <= 1, so the tail is head + buf_cnt mod 2.
  assign tail = head ^ buf_cnt[0];

  assign ram_cnt_nxt = ram_cnt + (DEPTH_LOG2+1)'(accept) - (DEPTH_LOG2+1)'(issue);
  assign buf_cnt_nxt = buf_cnt + {1'b0, rd_pending} - {1'b0, pop};
  assign count_nxt   = ram_cnt_nxt + (DEPTH_LOG2+1)'(issue)
                     + (DEPTH_LOG2+1)'(buf_cnt_nxt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      count_q     <= '0;
      rd_pending  <= 1'b0;
      buf_cnt     <= 2'd0;
      head        <= 1'b0;
      buf_data    <= '0;
      buf_perr    <= '0;
      ovf_q       <= 1'b0;
      perr_sticky <= 1'b0;
    end else if (FLUSH) begin
      // Any in-flight read is dropped by clearing rd_pending.
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      count_q     <= '0;
      rd_pending  <= 1'b0;
      buf_cnt     <= 2'd0;
      head        <= 1'b0;
      buf_data    <= '0;
      buf_perr    <= '0;
      ovf_q       <= WR_EN & FULL;
      perr_sticky <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (issue)  rptr <= rptr + 1'b1;
      ram_cnt    <= ram_cnt_nxt;
      count_q    <= count_nxt;
      rd_pending <= issue;
      buf_cnt    <= buf_cnt_nxt;
      if (rd_pending) begin
        buf_data[tail] <= RAM_RDATA_B;
        buf_perr[tail] <= cap_perr;
      end
      if (pop)      head        <= ~head;
      if (cap_perr) perr_sticky <= 1'b1;
      ovf_q <= WR_EN & FULL;
    end
  end

endmodule

// File: tb/tb_tdp18k_fifo_ctrl.sv
// Testbench for tdp18k_fifo_ctrl: behavioural RAM half, table-driven
// vectors, directed corner sequences and a queue-based reference model.
module tb_tdp18k_fifo_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK = 1'b0;
  logic        RESET, FLUSH, WR_EN, O_READY;
  logic [15:0] WR_DATA;
  logic        FULL, ALMOST_FULL, WR_OVERFLOW, O_VALID, O_PERR;
  logic [15:0] O_DATA;
  logic        EMPTY, ALMOST_EMPTY, PARITY_ERR;
  logic [10:0] COUNT;
  logic        RAM_WEN_A, RAM_REN_B;
  logic [1:0]  RAM_BE_A, RAM_WPARITY_A, RAM_RPARITY_B;
  logic [13:0] RAM_ADDR_A, RAM_ADDR_B;
  logic [15:0] RAM_WDATA_A, RAM_RDATA_B;

  always #5 CLK = ~CLK;

  tdp18k_fifo_ctrl dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .WR_OVERFLOW(WR_OVERFLOW),
    .O_VALID(O_VALID), .O_READY(O_READY), .O_DATA(O_DATA), .O_PERR(O_PERR),
    .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT),
    .PARITY_ERR(PARITY_ERR), .RAM_WEN_A(RAM_WEN_A), .RAM_BE_A(RAM_BE_A),
    .RAM_ADDR_A(RAM_ADDR_A), .RAM_WDATA_A(RAM_WDATA_A),
    .RAM_WPARITY_A(RAM_WPARITY_A), .RAM_REN_B(RAM_REN_B),
    .RAM_ADDR_B(RAM_ADDR_B), .RAM_RDATA_B(RAM_RDATA_B),
    .RAM_RPARITY_B(RAM_RPARITY_B)
  );

  // ---------------- RAM half model (1024 x 18) ----------------
  logic [17:0] mem [1024];
  logic [15:0] rd_q   = 16'h0;
  logic [1:0]  rp_q   = 2'b00;
  logic        flip_q = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [9:0]  corrupt_idx = 10'd0;

  always @(posedge CLK) begin
    if (RAM_WEN_A) mem[RAM_ADDR_A[13:4]] <= {RAM_WPARITY_A, RAM_WDATA_A};
    if (RAM_REN_B) begin
      rd_q   <= mem[RAM_ADDR_B[13:4]][15:0];
      rp_q   <= mem[RAM_ADDR_B[13:4]][17:16];
      flip_q <= corrupt_en && (RAM_ADDR_B[13:4] == corrupt_idx);
    end
  end
  assign RAM_RDATA_B   = rd_q;
  assign RAM_RPARITY_B = rp_q ^ {1'b0, flip_q};

  // ---------------- scoreboard / reference model ----------------
  logic [15:0] exp_q[$];
  logic        perr_q[$];
  int          arr_q[$];
  int          m_count;
  logic [9:0]  m_wptr;
  logic        m_ovf, m_perr_pushed, m_perr_seen;
  int          cyc, n_checks, n_pass, pops, first_pop, last_pop;

  typedef struct {
    logic        wr;
    logic [15:0] d;
    logic        rdy;
    logic        exp_wen;
    logic [1:0]  exp_wpar;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [10:0] exp_count;
  } vec_t;
  vec_t vt[15];
  vec_t cur_v;
  logic vec_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void m_reset();
    exp_q.delete(); perr_q.delete(); arr_q.delete();
    m_count = 0; m_wptr = '0; m_ovf = 1'b0;
    m_perr_pushed = 1'b0; m_perr_seen = 1'b0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_full"}, FULL, 0);          chk({tag, "_empty"}, EMPTY, 1);
    chk({tag, "_aempty"}, ALMOST_EMPTY, 1); chk({tag, "_afull"}, ALMOST_FULL, 0);
    chk({tag, "_valid"}, O_VALID, 0);      chk({tag, "_odata"}, O_DATA, 0);
    chk({tag, "_operr"}, O_PERR, 0);       chk({tag, "_count"}, COUNT, 0);
    chk({tag, "_ovf"}, WR_OVERFLOW, 0);    chk({tag, "_wen"}, RAM_WEN_A, 0);
    chk({tag, "_ren"}, RAM_REN_B, 0);      chk({tag, "_addra"}, RAM_ADDR_A, 0);
    chk({tag, "_addrb"}, RAM_ADDR_B, 0);   chk({tag, "_wdata"}, RAM_WDATA_A, 0);
    chk({tag, "_wpar"}, RAM_WPARITY_A, 0); chk({tag, "_be"}, RAM_BE_A, 0);
    chk({tag, "_perr"}, PARITY_ERR, 0);
  endtask

  // One clock: drive inputs, check against the model mid-cycle, advance model.
  task automatic step(input logic wr, input logic [15:0] d, input logic rdy, input logic fl);
    logic full_m, acc, pop;
    WR_EN = wr; WR_DATA = d; O_READY = rdy; FLUSH = fl;
    @(negedge CLK);
    full_m = (m_count == 1024);
    acc    = wr && !full_m && !fl;
    pop    = O_VALID && rdy;
    chk("count", COUNT, m_count);
    chk("full", FULL, full_m);
    chk("empty", EMPTY, m_count == 0);
    chk("almost_full", ALMOST_FULL, m_count >= 1020);
    chk("almost_empty", ALMOST_EMPTY, m_count <= 4);
    chk("wr_overflow", WR_OVERFLOW, m_ovf);
    chk("ram_wen", RAM_WEN_A, acc);
    if (acc) begin
      chk("ram_addr_a", RAM_ADDR_A, {m_wptr, 4'b0000});
      chk("ram_wdata", RAM_WDATA_A, d);
      chk("ram_wparity", RAM_WPARITY_A, {^d[15:8], ^d[7:0]});
      chk("ram_be", RAM_BE_A, 2'b11);
    end
    if (fl) chk("ren_on_flush", RAM_REN_B, 0);
    if (O_VALID) chk("valid_has_data", exp_q.size() != 0, 1);
    if (exp_q.size() != 0 && cyc >= arr_q[0] + 3) chk("valid_latency", O_VALID, 1);
    if (m_perr_seen) chk("parity_err_sticky", PARITY_ERR, 1);
    if (!m_perr_pushed) chk("parity_err_clear", PARITY_ERR, 0);
    if (vec_on) begin
      chk("vec_wen", RAM_WEN_A, cur_v.exp_wen);
      if (cur_v.exp_wen) chk("vec_wpar", RAM_WPARITY_A, cur_v.exp_wpar);
      chk("vec_valid", O_VALID, cur_v.exp_valid);
      if (cur_v.exp_valid) chk("vec_data", O_DATA, cur_v.exp_data);
      chk("vec_count", COUNT, cur_v.exp_count);
    end
    if (pop && exp_q.size() != 0) begin
      chk("pop_data", O_DATA, exp_q[0]);
      chk("pop_perr", O_PERR, perr_q[0]);
      if (perr_q[0]) m_perr_seen = 1'b1;
      void'(exp_q.pop_front()); void'(perr_q.pop_front()); void'(arr_q.pop_front());
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end
    if (acc) begin
      exp_q.push_back(d);
      perr_q.push_back(corrupt_en && (m_wptr == corrupt_idx));
      if (corrupt_en && (m_wptr == corrupt_idx)) m_perr_pushed = 1'b1;
      arr_q.push_back(cyc);
      m_wptr = m_wptr + 10'd1;
    end
    m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
    @(posedge CLK); #1;
    cyc++;
    m_ovf = wr && full_m;
    if (fl) begin
      logic ovf_keep;
      ovf_keep = m_ovf;
      m_reset();
      m_ovf = ovf_keep;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int steady;
    n_checks = 0; n_pass = 0; cyc = 0; pops = 0; first_pop = 0; last_pop = 0;
    m_reset();
    RESET = 1'b1; FLUSH = 1'b0; WR_EN = 1'b0; O_READY = 1'b0; WR_DATA = 16'h0;

    // Latency table from reset. 0x1234: low byte 0x34 has three ones, so
    // parity bit0 = 1; high byte 0x12 has two, so bit1 = 0.
    vt[0]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 2'b01, 1'b0, 16'h0,    11'd0};
    vt[1]  = '{1'b0, 16'h0,    1'b0, 1'b0, 2'b00, 1'b0, 16'h0,    11'd1};
    vt[2]  = '{1'b0, 16'h0,    1'b0, 1'b0, 2'b00, 1'b0, 16'h0,    11'd1};
    vt[3]  = '{1'b0, 16'h0,    1'b1, 1'b0, 2'b00, 1'b1, 16'h1234, 11'd1};
    vt[4]  = '{1'b1, 16'h01FF, 1'b1, 1'b1, 2'b10, 1'b0, 16'h0,    11'd0};
    vt[5]  = '{1'b1, 16'hA5A5, 1'b1, 1'b1, 2'b00, 1'b0, 16'h0,    11'd1};
    vt[6]  = '{1'b0, 16'h0,    1'b0, 1'b0, 2'b00, 1'b0, 16'h0,    11'd2};
    vt[7]  = '{1'b0, 16'h0,    1'b0, 1'b0, 2'b00, 1'b1, 16'h01FF, 11'd2};
    vt[8]  = '{1'b0, 16'h0,    1'b1, 1'b0, 2'b00, 1'b1, 16'h01FF, 11'd2};
    vt[9]  = '{1'b0, 16'h0,    1'b1, 1'b0, 2'b00, 1'b1, 16'hA5A5, 11'd1};
    vt[10] = '{1'b0, 16'h0,    1'b1, 1'b0, 2'b00, 1'b0, 16'h0,    11'd0};
    // After a mid-stream reset: 0xBEEF -> bit1 = ^0xBE = 0, bit0 = ^0xEF = 1.
    vt[11] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 2'b01, 1'b0, 16'h0,    11'd0};
    vt[12] = '{1'b0, 16'h0,    1'b0, 1'b0, 2'b00, 1'b0, 16'h0,    11'd1};
    vt[13] = '{1'b0, 16'h0,    1'b0, 1'b0, 2'b00, 1'b0, 16'h0,    11'd1};
    vt[14] = '{1'b0, 16'h0,    1'b1, 1'b0, 2'b00, 1'b1, 16'hBEEF, 11'd1};

    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("reset");
    @(posedge CLK); #1 RESET = 1'b0;

    vec_on = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cur_v = vt[i];
      step(vt[i].wr, vt[i].d, vt[i].rdy, 1'b0);
    end
    vec_on = 1'b0;

    // Fill to FULL with the consumer stalled, then one push too many.
    for (int i = 0; i < 1024; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("fill_count", COUNT, 1024);
    chk("fill_full", FULL, 1);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("overflow_pulse", WR_OVERFLOW, 1);
    chk("overflow_count", COUNT, 1024);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("overflow_one_cycle", WR_OVERFLOW, 0);

    // Drain: 1024 words in order, back to back.
    pops = 0;
    for (int i = 0; i < 1030; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drain_words", pops, 1024);
    chk("drain_back_to_back", last_pop - first_pop, 1023);
    chk("drain_empty", EMPTY, 1);
    chk("drain_valid", O_VALID, 0);

    // Streaming push + pop every cycle across pointer wrap.
    pops = 0; steady = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, 16'($urandom), 1'b1, 1'b0);
      if (i == 20) steady = int'(COUNT);
    end
    chk("stream_count_steady", COUNT, steady);
    chk("stream_throughput", pops >= 2990, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 299) == 0);
    for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("random_drained", EMPTY, 1);

    // Parity error injected on word 5, then FLUSH with data still queued.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    corrupt_idx = 10'd5; corrupt_en = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i * 16'h1111 + 16'h0102), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("perr_sticky_after_drain", PARITY_ERR, 1);
    corrupt_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("perr_before_flush", PARITY_ERR, 1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("flush_count", COUNT, 0);
    chk("flush_valid", O_VALID, 0);
    chk("flush_perr", PARITY_ERR, 0);

    // Reset mid-stream while a read is in flight.
    for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    WR_EN = 1'b1; O_READY = 1'b1;
    #3 RESET = 1'b1;
    #1 check_reset_outputs("midreset");
    @(posedge CLK); #1 RESET = 1'b0; WR_EN = 1'b0;
    m_reset();
    vec_on = 1'b1;
    for (int i = 11; i < 15; i++) begin
      cur_v = vt[i];
      step(vt[i].wr, vt[i].d, vt[i].rdy, 1'b0);
    end
    vec_on = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("midreset_no_stale", O_VALID, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
